// File: rtl/word_pkg.sv
// Shared constants, types and FSM states for the Skein word-select logic.
// The one-hot word decoder can take its width constants from here as well.
package word_pkg;

  localparam int WORDS = 16;
  localparam int IDX_W = 4;

  typedef logic [WORDS-1:0] word_mask_t;
  typedef logic [IDX_W-1:0] word_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set
// mask bit and a flag telling whether any bit is set (index is 0 otherwise).
module lsb_priority_enc #(
  parameter int WORDS = word_pkg::WORDS,
  parameter int IDX_W = word_pkg::IDX_W
) (
  input  logic [WORDS-1:0] i_mask,
  output logic [IDX_W-1:0] o_index,
  output logic             o_nonzero
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    o_index   = '0;
    o_nonzero = 1'b0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_index   = IDX_W'(i);
        o_nonzero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_index_encoder.sv
// Serialises a pending-word mask into ascending 4-bit word indices with a
// valid/ready handshake; feeds the word mux between hash core and host.
// Optional build macro: WORD_ENC_COUNT_EN adds remaining_o, the popcount of
// the words not yet accepted (including the one currently presented).
module word_index_encoder
  import word_pkg::*;
#(
  parameter int WORDS = word_pkg::WORDS,
  parameter int IDX_W = word_pkg::IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WORDS-1:0] mask_i,
  input  logic             flush_i,
  output logic [IDX_W-1:0] index_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef WORD_ENC_COUNT_EN
  output logic [IDX_W:0]   remaining_o,
`endif
  output logic             overrun_o
);

  enc_state_t       r_state;
  enc_state_t       w_nextState;
  logic [WORDS-1:0] r_mask;
  logic [WORDS-1:0] w_nextMask;
  logic [WORDS-1:0] w_clearedMask;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_encIndex;
  logic             w_encNonzero;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             w_nextDone;
  logic             w_nextOverrun;

  // Encoder looks at the mask as it will be after this edge, so the index
  // for the following cycle is ready without a bubble
  lsb_priority_enc #(
    .WORDS(WORDS),
    .IDX_W(IDX_W)
  ) u_lsbEnc (
    .i_mask   (w_nextMask),
    .o_index  (w_encIndex),
    .o_nonzero(w_encNonzero)
  );

  // Next-state, next-mask and pulse decode; flush overrides load and handshake
  always_comb begin
    w_nextState   = r_state;
    w_nextMask    = r_mask;
    w_nextDone    = 1'b0;
    w_nextOverrun = 1'b0;
    w_clearedMask = r_mask;
    w_clearedMask[r_index] = 1'b0;
    if (flush_i) begin
      w_nextState = IDLE;
      w_nextMask  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_i) begin
            if (mask_i != '0) begin
              w_nextState = EMIT;
              w_nextMask  = mask_i;
            end else begin
              w_nextDone = 1'b1;
            end
          end
        end
        EMIT: begin
          if (load_i) begin
            w_nextOverrun = 1'b1;
          end
          if (r_valid && ready_i) begin
            w_nextMask = w_clearedMask;
            if (w_clearedMask == '0) begin
              w_nextState = IDLE;
              w_nextDone  = 1'b1;
            end
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextMask  = '0;
        end
      endcase
    end
  end

  // State, mask and every output are registered together
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_index   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_mask    <= w_nextMask;
      r_index   <= w_encNonzero ? w_encIndex : '0;
      r_valid   <= (w_nextState == EMIT);
      r_busy    <= (w_nextState == EMIT);
      r_done    <= w_nextDone;
      r_overrun <= w_nextOverrun;
    end
  end

`ifdef WORD_ENC_COUNT_EN
  logic [IDX_W:0] w_nextRemaining;
  logic [IDX_W:0] r_remaining;

  // Popcount of the mask as it will be after this edge
  always_comb begin
    w_nextRemaining = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_nextRemaining = w_nextRemaining + (IDX_W + 1)'(w_nextMask[i]);
    end
  end

  // Remaining-word count tracks the mask register cycle for cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_remaining <= '0;
    end else begin
      r_remaining <= w_nextRemaining;
    end
  end

  assign remaining_o = r_remaining;
`endif

  assign index_o   = r_index;
  assign valid_o   = r_valid;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_word_index_encoder.sv
// Directed bench for word_index_encoder: hand-computed index sequences,
// stalls, empty loads, overrun, flush and asynchronous reset.
module tb_word_index_encoder;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        load_i = 1'b0;
   logic [15:0] mask_i = '0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [3:0]  index_o;
   logic        valid_o;
   logic        busy_o;
   logic        done_o;
   logic        overrun_o;
`ifdef WORD_ENC_COUNT_EN
   logic [4:0]  remaining_o;
`endif

   int errorCount = 0;
   int checkCount = 0;

   word_index_encoder dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (load_i),
      .mask_i     (mask_i),
      .flush_i    (flush_i),
      .index_o    (index_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
`ifdef WORD_ENC_COUNT_EN
      .remaining_o(remaining_o),
`endif
      .overrun_o  (overrun_o)
   );

   // Free-running 10 ns clock
   always #5 clk_i = ~clk_i;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge
   task automatic applyStimulus(input logic load, input logic [15:0] mask, input logic ready, input logic flush);
      load_i  = load;
      mask_i  = mask;
      ready_i = ready;
      flush_i = flush;
      @(posedge clk_i);
      #1;
   endtask

   // Check the handshake outputs as a group
   task automatic checkState(input string tag, input logic valid, input logic [3:0] index,
                             input logic busy, input logic done);
      checkOutput({tag, ".valid"}, 32'(valid_o), 32'(valid));
      if (valid) checkOutput({tag, ".index"}, 32'(index_o), 32'(index));
      checkOutput({tag, ".busy"}, 32'(busy_o), 32'(busy));
      checkOutput({tag, ".done"}, 32'(done_o), 32'(done));
   endtask

   // Directed scenarios
   initial begin
      // Reset values
      repeat (2) @(posedge clk_i);
      #1;
      checkState("reset", 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("reset.index", 32'(index_o), 32'd0);
      checkOutput("reset.overrun", 32'(overrun_o), 32'd0);
`ifdef WORD_ENC_COUNT_EN
      checkOutput("reset.remaining", 32'(remaining_o), 32'd0);
`endif
      @(negedge clk_i);
      rst_n_i = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkState("idle", 1'b0, 4'd0, 1'b0, 1'b0);

      // 16'h8421 with ready held high: 0,5,10,15 then done
      applyStimulus(1'b1, 16'h8421, 1'b1, 1'b0);
      checkState("m8421.i0", 1'b1, 4'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m8421.i5", 1'b1, 4'd5, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m8421.i10", 1'b1, 4'd10, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m8421.i15", 1'b1, 4'd15, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m8421.done", 1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m8421.after", 1'b0, 4'd0, 1'b0, 1'b0);

      // 16'h0006 with a three-cycle stall
      applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
      checkState("m0006.first", 1'b1, 4'd1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
         checkState("m0006.stall", 1'b1, 4'd1, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m0006.i2", 1'b1, 4'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("m0006.done", 1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkState("m0006.once", 1'b0, 4'd0, 1'b0, 1'b0);

      // Empty mask: immediate done, never valid
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
      checkState("empty.done", 1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("empty.after", 1'b0, 4'd0, 1'b0, 1'b0);

      // 16'hFFFF with loads mid-sequence and on the last handshake
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checkState($sformatf("mFFFF.i%0d", i), 1'b1, 4'(i), 1'b1, 1'b0);
         checkOutput($sformatf("mFFFF.overrun%0d", i), 32'(overrun_o), (i == 4) ? 32'd1 : 32'd0);
`ifdef WORD_ENC_COUNT_EN
         checkOutput($sformatf("mFFFF.remaining%0d", i), 32'(remaining_o), 32'(16 - i));
`endif
         applyStimulus((i == 3) || (i == 15), 16'h0001, 1'b1, 1'b0);
      end
      checkState("mFFFF.done", 1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("mFFFF.lastOverrun", 32'(overrun_o), 32'd1);
`ifdef WORD_ENC_COUNT_EN
      checkOutput("mFFFF.remainingEnd", 32'(remaining_o), 32'd0);
`endif

      // A load in the done cycle is accepted
      applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0);
      checkState("doneLoad.i4", 1'b1, 4'd4, 1'b1, 1'b0);
      checkOutput("doneLoad.overrun", 32'(overrun_o), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("doneLoad.done", 1'b0, 4'd0, 1'b0, 1'b1);

      // 16'h00F0, flush after two handshakes beats load and handshake
      applyStimulus(1'b1, 16'h00F0, 1'b1, 1'b0);
      checkState("flush.i4", 1'b1, 4'd4, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("flush.i5", 1'b1, 4'd5, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("flush.i6", 1'b1, 4'd6, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h0200, 1'b1, 1'b1);
      checkState("flush.cut", 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("flush.overrun", 32'(overrun_o), 32'd0);
`ifdef WORD_ENC_COUNT_EN
      checkOutput("flush.remaining", 32'(remaining_o), 32'd0);
`endif
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
      checkState("flush.reload", 1'b1, 4'd8, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkState("flush.reloadDone", 1'b0, 4'd0, 1'b0, 1'b1);

      // Asynchronous reset during the first valid cycle
      applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
      checkState("arst.before", 1'b1, 4'd0, 1'b1, 1'b0);
      rst_n_i = 1'b0;
      #1;
      checkState("arst.during", 1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("arst.index", 32'(index_o), 32'd0);
      load_i  = 1'b0;
      ready_i = 1'b1;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
         checkState("arst.after", 1'b0, 4'd0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
